// File: rtl/moment_ram_reader.sv
// Read-side sequencer for a moment RAM: sweeps all lattice addresses in raster order and streams
// each word with (x,y,last) tags, absorbing the RAM read latency in a credit-controlled FIFO.
module moment_ram_reader #(
  parameter int unsigned GRID_X        = 16,
  parameter int unsigned GRID_Y        = 16,
  parameter int unsigned DEPTH         = GRID_X * GRID_Y,
  parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           start,
  output logic [ADDRESS_WIDTH-1:0]       address,
  input  logic signed [DATA_WIDTH-1:0]   data_out,
  output logic signed [DATA_WIDTH-1:0]   m_data,
  output logic [$clog2(GRID_X)-1:0]      m_x,
  output logic [$clog2(GRID_Y)-1:0]      m_y,
  output logic                           m_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned XW = $clog2(GRID_X);
  localparam int unsigned YW = $clog2(GRID_Y);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = DATA_WIDTH + XW + YW + 1;

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] idx_q, addr_q;
  logic [XW-1:0]            x_q, in_x_q;
  logic [YW-1:0]            y_q, in_y_q;
  logic                     inflight_q, in_last_q;
  logic [EW-1:0]            mem [FIFO_DEPTH];
  logic [PW-1:0]            rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]            count_q;
  logic                     done_q;

  logic                     issue, push, pop, is_last_addr, start_ok;
  logic [EW-1:0]            head;

  // An issue needs a free slot for the word already in the RAM pipeline as well as its own.
  assign issue        = (state_q == StRead) &&
                        (({1'b0, count_q} + (CW + 1)'(inflight_q)) < (CW + 1)'(FIFO_DEPTH));
  assign is_last_addr = (idx_q == ADDRESS_WIDTH'(DEPTH - 1));
  assign start_ok     = (state_q == StIdle) && start && !done_q;
  assign push         = inflight_q;
  assign pop          = m_valid && m_ready;
  assign head         = mem[rd_ptr_q];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StRead;
      StRead:  if (issue && is_last_addr) state_d = StDrain;
      StDrain: if (pop && head[EW-1]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy    = (state_q != StIdle);
    done    = done_q;
    address = issue ? idx_q : addr_q;
    m_valid = (count_q != '0);
    m_last  = m_valid ? head[EW-1] : 1'b0;
    m_y     = m_valid ? head[EW-2 -: YW] : '0;
    m_x     = m_valid ? head[DATA_WIDTH +: XW] : '0;
    m_data  = m_valid ? head[DATA_WIDTH-1:0] : '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx_q      <= '0;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      in_x_q     <= '0;
      in_y_q     <= '0;
      in_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= (state_q == StDrain) && pop && head[EW-1];
      inflight_q <= issue;
      if (start_ok) begin
        idx_q <= '0;
        x_q   <= '0;
        y_q   <= '0;
      end else if (issue) begin
        idx_q     <= idx_q + ADDRESS_WIDTH'(1);
        addr_q    <= idx_q;
        in_x_q    <= x_q;
        in_y_q    <= y_q;
        in_last_q <= is_last_addr;
        if (x_q == XW'(GRID_X - 1)) begin
          x_q <= '0;
          y_q <= y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset: the outputs are masked while the FIFO is empty.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr_q] <= {in_last_q, in_y_q, in_x_q, data_out};
  end

  fifo_no_overflow: assert property (@(posedge Clk) disable iff (Reset)
    !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_moment_ram_reader.sv
// Directed bench for moment_ram_reader: behavioural RAM, per-beat tag/data checks, handshake
// stability, backpressure, start-while-busy and mid-sweep reset.
module tb_moment_ram_reader;
  localparam int N = 256;

  logic        Clk = 1'b0;
  logic        Reset, start, m_ready;
  logic [7:0]  address;
  logic [63:0] data_out, m_data;
  logic [3:0]  m_x, m_y;
  logic        m_last, m_valid, busy, done;

  logic [63:0] ram [N];
  int          errors = 0;
  int          checks = 0;
  int          pat = 0;

  moment_ram_reader dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .address  (address),
    .data_out (data_out),
    .m_data   (m_data),
    .m_x      (m_x),
    .m_y      (m_y),
    .m_last   (m_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) data_out <= ram[address];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word(input int a);
    return (pat == 0) ? (64'(a) << 56) : (64'h8000_0000_0000_0000 | 64'(a));
  endfunction

  function automatic logic [72:0] beat_exp(input int a);
    return {(a == N - 1), a[7:4], a[3:0], word(a)};
  endfunction

  task automatic load_ram();
    for (int i = 0; i < N; i++) ram[i] = word(i);
  endtask

  // rmode: 0 = always ready, 1 = 10-cycle stall at beat 5, 2 = random ready
  task automatic stream(input int rmode, input bit extra_start, input int abort_at);
    int          beat, dones, last_cyc, stall_cnt;
    bit          last_seen, aborted, prev_v, prev_r, s20, s255;
    logic [72:0] cur, prev_t;
    logic [7:0]  addr0;
    beat = 0; dones = 0; last_cyc = 0; stall_cnt = 0;
    last_seen = 0; aborted = 0; prev_v = 0; prev_r = 0; s20 = 0; s255 = 0;
    prev_t = '0; addr0 = '0;
    @(posedge Clk); #1;
    start   = 1'b1;
    m_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge Clk);
      cur = {m_last, m_y, m_x, m_data};
      if (aborted) begin
        check("abort_valid", m_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        break;
      end
      if (cyc == 1) check("start_busy", busy, 1'b1);
      if (cyc == 1 || cyc == 2) check("latency_low", m_valid, 1'b0);
      if (cyc == 3) check("latency_high", m_valid, 1'b1);
      if (rmode == 0 && abort_at < 0 && cyc >= 3 && cyc <= 258) check("no_gap", m_valid, 1'b1);
      if (prev_v && !prev_r) check("hold", {m_valid, cur}, {1'b1, prev_t});
      if (rmode == 1 && !m_ready) begin
        check("bp_addr_bound", address <= 8'd8, 1'b1);
        if (stall_cnt == 6) addr0 = address;
        if (stall_cnt > 6) check("bp_addr_hold", address, addr0);
        if (stall_cnt == 10) check("bp_head", m_data, word(5));
      end
      if (done) dones++;
      if (last_seen && cyc == last_cyc + 1) begin
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b0);
      end
      if (last_seen && cyc > last_cyc + 1) check("idle_after", m_valid, 1'b0);
      if (m_valid && m_ready) begin
        check("beat", cur, beat_exp(beat));
        beat++;
        if (m_last) begin
          last_seen = 1;
          last_cyc  = cyc;
        end
      end
      prev_v = m_valid;
      prev_r = m_ready;
      prev_t = cur;
      if (last_seen && cyc >= last_cyc + 4) break;
      @(posedge Clk); #1;
      start = 1'b0;
      if (extra_start && beat == 21 && !s20) begin
        start = 1'b1;
        s20   = 1;
      end
      if (extra_start && beat == N && !s255) begin
        start = 1'b1;
        s255  = 1;
      end
      case (rmode)
        1: begin
          if (beat == 5 && stall_cnt < 10) begin
            m_ready = 1'b0;
            stall_cnt++;
          end else begin
            m_ready = 1'b1;
          end
        end
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      if (abort_at >= 0 && beat == abort_at + 1) begin
        Reset   = 1'b1;
        aborted = 1;
      end
    end
    start = 1'b0;
    if (abort_at < 0) begin
      check("timeout", last_seen, 1'b1);
      check("beat_count", beat, N);
      check("done_count", dones, 1);
    end else begin
      check("abort_reached", aborted, 1'b1);
    end
  endtask

  initial begin
    Reset   = 1'b1;
    start   = 1'b0;
    m_ready = 1'b1;
    pat     = 0;
    load_ram();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_outs", {address, m_data, m_x, m_y, m_last, m_valid, busy, done}, '0);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("idle_quiet", {m_valid, done, busy}, 3'b000);
    end

    stream(0, 1'b0, -1);

    stream(1, 1'b0, -1);

    pat = 1;
    load_ram();
    stream(2, 1'b0, -1);

    pat = 0;
    load_ram();
    stream(0, 1'b1, -1);

    stream(0, 1'b0, 100);
    @(posedge Clk); #1;
    Reset = 1'b0;
    stream(0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
